pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter CNT_W SHALL default to 16 and set the stall-counter width.
REQ-003 Parameter WAIT_MAX SHALL default to 255 and set the maximum number of data-memory wait cycles before an error.
REQ-004 The ports SHALL be (name, direction, width, meaning):
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-high reset.
- id_rs  in  5  rs field in IF/ID.
- id_rt  in  5  rt field in IF/ID.
- id_use_rt  in  1  ID instruction reads rt (R-format, BEQ, SW).
- ex_memread  in  1  ID/EX MEM[0] (MemRead).
- ex_rt  in  5  ID/EX destination rt.
- ex_take  in  1  branch or jump taken, resolved in EX.
- mem_req  in  1  EX/MEM MemRead|MemWrite.
- mem_ready  in  1  data-memory completion.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID write enable.
- ifid_flush  out  1  IF/ID to NOP.
- idex_we  out  1  ID/EX write enable.
- idex_flush  out  1  ID/EX control to zero (bubble).
- exmem_we  out  1  EX/MEM write enable.
- memwb_bubble  out  1  MEM/WB RegWrite forced to 0.
- state  out  2  FSM state.
- err  out  1  sticky memory timeout.
- stall_cnt  out  CNT_W  stall counter.

Function
REQ-005 The FSM SHALL have three states, encoded RUN=0, WAIT=1 and ERR=2, and each output SHALL be a function of the state and the current inputs.
REQ-006 In RUN, a memory stall is `mem_req && !mem_ready`, and it SHALL take priority.
- Same-cycle outputs: pc_we=ifid_we=idex_we=exmem_we=0, memwb_bubble=1, flushes=0.
- Next state: WAIT.
REQ-007 In RUN, if there is no memory stall and ex_take=1, then:
- ifid_flush=1 and idex_flush=1.
- All enables=1.
- Branch taken overrides load-use.
REQ-008 In RUN, a load-use hazard is `ex_memread && ex_rt!=0 && (ex_rt==id_rs || (id_use_rt && ex_rt==id_rt))`; with no stall or taken branch, it SHALL give pc_we=0, ifid_we=0 and idex_flush=1, with the other enables at 1.
- Exactly one bubble per hazard.
- No extra state.
REQ-009 In RUN with no event, all enables SHALL be 1 and all flushes/bubble SHALL be 0.
REQ-010 In WAIT, the outputs SHALL be the same as REQ-006, and wait_ctr (8 bits or more, internal) SHALL increment every cycle.
- When mem_ready=1, enables=1 that cycle, wait_ctr clears, next state RUN.
- When wait_ctr==WAIT_MAX-1 with mem_ready=0, next state ERR.
REQ-011 In ERR, all enables SHALL be 0, memwb_bubble SHALL be 1 and err SHALL be 1, and the FSM SHALL leave ERR only through reset.
REQ-012 ex_take and the load-use hazard SHALL be ignored in WAIT and ERR, and are re-evaluated in the first RUN cycle.
REQ-013 A mem_ready that is high while mem_req=0 SHALL be ignored.

Reset
REQ-014 When rst=1, the outputs SHALL be:
- state=RUN, wait_ctr=0, err=0, stall_cnt=0.
- Outputs per REQ-009 for the current inputs.
REQ-015 Reset in WAIT or ERR SHALL abort the wait immediately, with no further memwb_bubble after rst rises.

Configuration
REQ-016 With `HAZ_PERF_CNT_EN` defined, stall_cnt SHALL increment in each cycle where pc_we=0, and SHALL saturate at all-ones.
REQ-017 With `HAZ_PERF_CNT_EN` undefined, stall_cnt SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-018 Package pipe_ctrl_pkg SHALL hold:
- The state enum (RUN/WAIT/ERR).
- The opcode constants (R_FORMAT=0, J=2, BEQ=4, BNE=5, ORI=13, LW=35, SW=43).
- The default WAIT_MAX.
REQ-019 The load-use compare SHALL be a sub-module, haz_loaduse_cmp.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- LW $5 in EX and ID reads rs=5 -> one cycle with pc_we=0, ifid_we=0, idex_flush=1, then all enables=1.
- LW $0 in EX and ID reads rs=0 -> no stall.
- ex_take=1 together with a load-use hazard -> ifid_flush=idex_flush=1 and pc_we=1.
- mem_req=1, with mem_ready rising after 3 cycles -> 4 frozen cycles (pc_we=0) including the cycle of the initial RUN detection, then RUN.
  - With HAZ_PERF_CNT_EN, stall_cnt=4.
- WAIT_MAX=4 and mem_ready held at 0 -> ERR on the 5th cycle, err=1 held until rst, then state=0 and err=0.
- rst asserted mid-WAIT -> state=RUN asynchronously and all enables=1 on the next edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding, MIPS opcode constants and the default memory timeout.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [5:0] R_FORMAT = 6'd0;
  localparam logic [5:0] J        = 6'd2;
  localparam logic [5:0] BEQ      = 6'd4;
  localparam logic [5:0] BNE      = 6'd5;
  localparam logic [5:0] ORI      = 6'd13;
  localparam logic [5:0] LW       = 6'd35;
  localparam logic [5:0] SW       = 6'd43;

  localparam int WAIT_MAX_DEFAULT = 255;

endpackage

// File: rtl/haz_loaduse_cmp.sv
// Load-use comparator: flags a load in EX whose destination is read by the instruction in ID.
// Register $0 never creates a dependency.
module haz_loaduse_cmp (
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_use_rt,
  output logic       o_hazard
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = (i_ex_rt == i_id_rs);
  assign w_rt_hit = i_id_use_rt && (i_ex_rt == i_id_rt);
  assign o_hazard = i_ex_memread && (i_ex_rt != 5'd0) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and data-memory wait/timeout.
// Define HAZ_PERF_CNT_EN to build the saturating stall performance counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_take,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             memwb_bubble,
  output logic [1:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WCTR_W = ($clog2(WAIT_MAX + 1) > 8) ? $clog2(WAIT_MAX + 1) : 8;
  localparam logic [WCTR_W-1:0] WCTR_LAST = WCTR_W'(WAIT_MAX - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WCTR_W-1:0] r_wait_ctr;
  logic [WCTR_W-1:0] w_wait_ctr_nxt;
  logic              w_loaduse;
  logic              w_mem_stall;
  logic              w_mem_done;

  haz_loaduse_cmp u_loaduse (
    .i_ex_memread (ex_memread),
    .i_ex_rt      (ex_rt),
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .i_id_use_rt  (id_use_rt),
    .o_hazard     (w_loaduse)
  );

  // mem_ready only means something while a memory access is outstanding
  assign w_mem_stall = mem_req && !mem_ready;
  assign w_mem_done  = mem_req && mem_ready;

  // State and wait-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_ctr <= {WCTR_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_wait_ctr <= w_wait_ctr_nxt;
    end
  end

  // Next-state and pipeline-control decode; reset forces the free-running pattern
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_ctr_nxt = r_wait_ctr;
    pc_we          = 1'b1;
    ifid_we        = 1'b1;
    ifid_flush     = 1'b0;
    idex_we        = 1'b1;
    idex_flush     = 1'b0;
    exmem_we       = 1'b1;
    memwb_bubble   = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          pc_we          = 1'b0;
          ifid_we        = 1'b0;
          idex_we        = 1'b0;
          exmem_we       = 1'b0;
          memwb_bubble   = 1'b1;
          w_state_nxt    = WAIT;
          w_wait_ctr_nxt = {WCTR_W{1'b0}};
        end else if (ex_take) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (w_loaduse) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
        end else begin
          w_state_nxt = RUN;
        end
      end
      WAIT: begin
        if (w_mem_done) begin
          w_state_nxt    = RUN;
          w_wait_ctr_nxt = {WCTR_W{1'b0}};
        end else begin
          pc_we          = 1'b0;
          ifid_we        = 1'b0;
          idex_we        = 1'b0;
          exmem_we       = 1'b0;
          memwb_bubble   = 1'b1;
          w_wait_ctr_nxt = r_wait_ctr + WCTR_W'(1);
          if (r_wait_ctr == WCTR_LAST) begin
            w_state_nxt = ERR;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      ERR: begin
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        idex_we      = 1'b0;
        exmem_we     = 1'b0;
        memwb_bubble = 1'b1;
        w_state_nxt  = ERR;
      end
      default: begin
        w_state_nxt    = RUN;
        w_wait_ctr_nxt = {WCTR_W{1'b0}};
      end
    endcase
    if (rst) begin
      pc_we        = 1'b1;
      ifid_we      = 1'b1;
      ifid_flush   = 1'b0;
      idex_we      = 1'b1;
      idex_flush   = 1'b0;
      exmem_we     = 1'b1;
      memwb_bubble = 1'b0;
    end else begin
      w_wait_ctr_nxt = w_wait_ctr_nxt;
    end
  end

  assign state = r_state;
  assign err   = (r_state == ERR);

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of cycles in which the PC is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (!pc_we && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule
